// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: boot-loads instruction memory from a valid/ready stream, then sequences the fetch PC
module imem_fetch_ctrl #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [31:0]           load_data,
  input  logic                  load_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [31:0]           imem_wdata,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_target,
  input  logic                  restart,
  output logic [31:0]           fetch_pc,
  output logic                  fetch_valid,
  output logic [ADDR_WIDTH:0]   prog_len,
  output logic                  halted,
  output logic                  load_err,
  output logic                  misalign_err
);
  typedef enum logic [1:0] {LOAD = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [31:0]           pc_q, pc_d, pc_nxt;
  logic                  lerr_q, lerr_d, mis_q, mis_d;
  logic                  hs, cur_in, nxt_in;
  logic [29:0]           len_ext;
  assign len_ext    = {{(29 - ADDR_WIDTH){1'b0}}, len_q};
  assign hs         = load_valid & load_ready;
  assign pc_nxt     = branch_taken ? {branch_target[31:2], 2'b00} : stall ? pc_q : pc_q + 32'd4;
  assign cur_in     = pc_q[31:2] < len_ext;
  assign nxt_in     = pc_nxt[31:2] < len_ext;
  assign load_ready = state_q == LOAD;
  assign imem_we    = hs;
  assign imem_waddr = wptr_q;
  assign imem_wdata = load_data;
  assign fetch_pc   = pc_q;
  assign fetch_valid = (state_q == RUN) & cur_in;
  assign prog_len   = len_q;
  assign halted     = state_q == HALT;
  assign load_err   = lerr_q;
  assign misalign_err = mis_q;
  // next-state: load writes and overflow in LOAD, PC sequencing and halt detection in RUN, restart from HALT
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    len_d   = len_q;
    pc_d    = pc_q;
    lerr_d  = lerr_q;
    mis_d   = mis_q;
    unique case (state_q)
      LOAD: if (hs) begin
        wptr_d = wptr_q + 1'b1;
        len_d  = len_q + 1'b1;
        if (load_last || (&wptr_q)) begin
          state_d = RUN;
          pc_d    = RESET_PC;
          lerr_d  = lerr_q | ~load_last;
        end
      end
      RUN: begin
        pc_d    = pc_nxt;
        mis_d   = mis_q | (branch_taken & (branch_target[1:0] != 2'b00));
        state_d = ((branch_taken | ~stall) & ~nxt_in) ? HALT : RUN;
      end
      HALT: if (restart) begin
        state_d = LOAD;
        wptr_d  = '0;
        len_d   = '0;
        pc_d    = RESET_PC;
      end
      default: state_d = LOAD;
    endcase
  end
  // state register with synchronous active-low reset; memory contents are left untouched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      wptr_q  <= '0;
      len_q   <= '0;
      pc_q    <= RESET_PC;
      lerr_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      len_q   <= len_d;
      pc_q    <= pc_d;
      lerr_q  <= lerr_d;
      mis_q   <= mis_d;
    end
  end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: table vectors, hand sequences and random stimulus against a behavioural model
module tb_imem_fetch_ctrl;
  localparam int          AW    = 10;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n, load_valid, load_ready, load_last, imem_we;
  logic [31:0] load_data, imem_wdata, branch_target, fetch_pc;
  logic [AW-1:0] imem_waddr;
  logic        stall, branch_taken, restart, fetch_valid, halted, load_err, misalign_err;
  logic [AW:0] prog_len;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.ADDR_WIDTH(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .restart(restart),
    .fetch_pc(fetch_pc), .fetch_valid(fetch_valid), .prog_len(prog_len),
    .halted(halted), .load_err(load_err), .misalign_err(misalign_err)
  );

  int checks = 0;
  int errors = 0;

  int          m_st;
  int          m_plen;
  logic [31:0] m_pc;
  bit          m_lerr, m_mis;

  typedef struct {
    logic        lv;
    logic [31:0] ld;
    logic        last, st, br;
    logic [31:0] bt;
    logic        rs;
    logic [31:0] e_pc;
    logic        e_fv, e_we;
    int          e_waddr, e_plen;
    logic        e_halt, e_mis;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic lv, input logic [31:0] ld, input logic last, input logic st,
                        input logic br, input logic [31:0] bt, input logic rs);
    load_valid = lv; load_data = ld; load_last = last; stall = st;
    branch_taken = br; branch_target = bt; restart = rs;
  endtask

  task automatic sample();
    logic we_exp;
    #3;
    we_exp = (m_st == 0) && load_valid;
    chk("load_ready", load_ready, m_st == 0);
    chk("imem_we", imem_we, we_exp);
    if (we_exp) begin
      chk("imem_waddr", imem_waddr, m_plen);
      chk("imem_wdata", imem_wdata, load_data);
    end
    chk("fetch_pc", fetch_pc, m_pc);
    chk("fetch_valid", fetch_valid, (m_st == 1) && ((m_pc >> 2) < m_plen));
    chk("prog_len", prog_len, m_plen);
    chk("halted", halted, m_st == 2);
    chk("load_err", load_err, m_lerr);
    chk("misalign_err", misalign_err, m_mis);
  endtask

  task automatic edge_step();
    logic [31:0] npc;
    @(posedge clk);
    if (!rst_n) begin
      m_st = 0; m_plen = 0; m_pc = RPC; m_lerr = 0; m_mis = 0;
    end else if (m_st == 0) begin
      if (load_valid) begin
        m_plen++;
        if (load_last || m_plen == DEPTH) begin
          if (!load_last) m_lerr = 1;
          m_st = 1;
          m_pc = RPC;
        end
      end
    end else if (m_st == 1) begin
      if (branch_taken) begin
        npc = branch_target & ~32'd3;
        if (branch_target % 4 != 0) m_mis = 1;
      end else npc = stall ? m_pc : m_pc + 32'd4;
      if ((branch_taken || !stall) && (npc >> 2) >= m_plen) m_st = 2;
      m_pc = npc;
    end else if (restart) begin
      m_st = 0; m_plen = 0; m_pc = RPC;
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    edge_step();
  endtask

  task automatic add(input logic lv, input logic [31:0] ld, input logic last, input logic st,
                     input logic br, input logic [31:0] bt, input logic rs, input logic [31:0] pc,
                     input logic fv, input logic we, input int wa, input int pl,
                     input logic h, input logic mis);
    vec_t v;
    v.lv = lv; v.ld = ld; v.last = last; v.st = st; v.br = br; v.bt = bt; v.rs = rs;
    v.e_pc = pc; v.e_fv = fv; v.e_we = we; v.e_waddr = wa; v.e_plen = pl; v.e_halt = h; v.e_mis = mis;
    tbl.push_back(v);
  endtask

  logic [31:0] words [8];
  int n;

  initial begin
    words = '{32'h01095020, 32'hAC0A0000, 32'h8C0B0004, 32'h016C6822,
              32'h11AE0002, 32'h00000000, 32'h01CF8025, 32'h02939824};
    for (int i = 0; i < 8; i++) add(1, words[i], i == 7, 0, 0, 0, 0, 0, 0, 1, i, i, 0, 0);
    add(0, 0, 0, 0, 0, 0,     0, 32'h0,   1, 0, 0, 8, 0, 0);
    add(0, 0, 0, 0, 0, 0,     1, 32'h4,   1, 0, 0, 8, 0, 0);
    add(0, 0, 0, 1, 0, 0,     0, 32'h8,   1, 0, 0, 8, 0, 0);
    add(0, 0, 0, 1, 0, 0,     0, 32'h8,   1, 0, 0, 8, 0, 0);
    add(0, 0, 0, 1, 1, 4,     0, 32'h8,   1, 0, 0, 8, 0, 0);
    add(0, 0, 0, 0, 1, 6,     0, 32'h4,   1, 0, 0, 8, 0, 0);
    add(0, 0, 0, 0, 0, 0,     0, 32'h4,   1, 0, 0, 8, 0, 1);
    add(0, 0, 0, 0, 1, 'h100, 0, 32'h8,   1, 0, 0, 8, 0, 1);
    add(0, 0, 0, 0, 0, 0,     1, 32'h100, 0, 0, 0, 8, 1, 1);
    add(1, 32'hA5A5_0001, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,     0, 32'h0,   0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0,     0, 32'h0,   0, 0, 0, 1, 0, 1);
    add(1, 32'hA5A5_0002, 1, 0, 0, 0, 0, 32'h0, 0, 1, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0,     0, 32'h0,   1, 0, 0, 2, 0, 1);
    add(0, 0, 0, 0, 0, 0,     0, 32'h4,   1, 0, 0, 2, 0, 1);
    add(0, 0, 0, 1, 1, 0,     0, 32'h8,   0, 0, 0, 2, 1, 1);
    add(0, 0, 0, 0, 0, 0,     0, 32'h8,   0, 0, 0, 2, 1, 1);

    rst_n = 0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    edge_step();
    rst_n = 1;
    foreach (tbl[i]) begin
      set_in(tbl[i].lv, tbl[i].ld, tbl[i].last, tbl[i].st, tbl[i].br, tbl[i].bt, tbl[i].rs);
      sample();
      chk($sformatf("tbl%0d.fetch_pc", i), fetch_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d.fetch_valid", i), fetch_valid, tbl[i].e_fv);
      chk($sformatf("tbl%0d.imem_we", i), imem_we, tbl[i].e_we);
      if (tbl[i].e_we) chk($sformatf("tbl%0d.imem_waddr", i), imem_waddr, tbl[i].e_waddr);
      chk($sformatf("tbl%0d.prog_len", i), prog_len, tbl[i].e_plen);
      chk($sformatf("tbl%0d.halted", i), halted, tbl[i].e_halt);
      chk($sformatf("tbl%0d.misalign_err", i), misalign_err, tbl[i].e_mis);
      edge_step();
    end

    rst_n = 0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc();
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      set_in(1, words[i], i == 7, 0, 0, 0, 0);
      cyc();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      sample();
      chk("seq_run.fetch_pc", fetch_pc, i * 4);
      chk("seq_run.fetch_valid", fetch_valid, 1);
      edge_step();
    end
    sample();
    chk("seq_end.fetch_pc", fetch_pc, 32);
    chk("seq_end.halted", halted, 1);
    chk("seq_end.fetch_valid", fetch_valid, 0);
    edge_step();

    rst_n = 0;
    cyc();
    rst_n = 1;
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1, i, 0, 0, 0, 0, 0);
      sample();
      if (i == DEPTH - 1) chk("ovf.last_waddr", imem_waddr, DEPTH - 1);
      edge_step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("ovf.load_err", load_err, 1);
    chk("ovf.prog_len", prog_len, DEPTH);
    chk("ovf.load_ready", load_ready, 0);
    chk("ovf.fetch_valid", fetch_valid, 1);
    edge_step();
    n = 0;
    while (!halted && n < DEPTH + 20) begin
      cyc();
      n++;
    end
    chk("ovf.halted", halted, 1);
    chk("ovf.halt_pc", fetch_pc, 4 * DEPTH);
    set_in(0, 0, 0, 0, 0, 0, 1);
    cyc();
    set_in(0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("restart.prog_len", prog_len, 0);
    chk("restart.load_ready", load_ready, 1);
    chk("restart.load_err_sticky", load_err, 1);
    edge_step();
    set_in(1, 32'h1234, 0, 0, 0, 0, 0); cyc();
    set_in(1, 32'h5678, 1, 0, 0, 0, 0); cyc();
    set_in(0, 0, 0, 0, 1, 32'h2, 0); cyc();
    rst_n = 0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc();
    rst_n = 1;
    sample();
    chk("midrun_rst.load_err", load_err, 0);
    chk("midrun_rst.misalign_err", misalign_err, 0);
    chk("midrun_rst.prog_len", prog_len, 0);
    chk("midrun_rst.load_ready", load_ready, 1);
    edge_step();

    for (int i = 0; i < 4000; i++) begin
      rst_n = $urandom_range(0, 199) != 0;
      set_in($urandom_range(0, 1), $urandom, $urandom_range(0, 15) == 0,
             $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
             $urandom_range(0, 160), $urandom_range(0, 4) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Sequences the instruction memory across its whole life: boot-loads the program into it through a valid/ready stream, then generates the fetch PC. It sits between the external loader/testbench and the instruction memory / IF stage of the pipelined MIPS core. In RUN it handles hazard stalls and branch redirects from the ID stage. It stops fetching once the PC leaves the loaded program.

Parameters:
ADDR_WIDTH, 10, word-address width of instruction memory (DEPTH = 2**ADDR_WIDTH = 1024 words)
RESET_PC, 32'h0000_0000, first fetch address after load completes; must be 4-byte aligned

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
load_valid  in  1  loader word valid
load_ready  out  1  controller accepts a loader word
load_data  in  32  instruction word to store
load_last  in  1  marks the final word of the program
imem_we  out  1  instruction memory write enable
imem_waddr  out  ADDR_WIDTH  instruction memory word write address
imem_wdata  out  32  instruction memory write data
stall  in  1  hazard unit: hold PC
branch_taken  in  1  ID stage: redirect fetch
branch_target  in  32  redirect byte address
restart  in  1  from HALT, return to LOAD
fetch_pc  out  32  byte address presented to instruction memory
fetch_valid  out  1  fetch_pc is a valid in-program fetch
prog_len  out  ADDR_WIDTH+1  number of words loaded (0..DEPTH)
halted  out  1  state == HALT
load_err  out  1  sticky: load overflow
misalign_err  out  1  sticky: branch_target[1:0] != 0

Behaviour:
- Reset (rst_n=0 at posedge):
  - state = LOAD, fetch_pc = RESET_PC, prog_len = 0, write pointer = 0.
  - fetch_valid = 0, imem_we = 0, load_err = 0, misalign_err = 0.
  - Reset mid-load or mid-run abandons all progress. Memory contents are not cleared.
- States: LOAD, RUN, HALT (2-bit encoding, internal).
- LOAD:
  - load_ready = 1.
  - Handshake = load_valid & load_ready at posedge. On each handshake, in the same cycle (combinational):
    - imem_we = 1
    - imem_waddr = write pointer
    - imem_wdata = load_data
  - At that edge: write pointer +1, prog_len +1.
  - load_valid=0: no write. Load data may be held indefinitely.
  - Handshake with load_last=1: next state RUN.
  - Handshake with write pointer == DEPTH-1 and load_last=0: the word is written, load_err set, next state RUN. No wrap to address 0.
  - fetch_valid = 0 throughout LOAD.
- Transition into RUN:
  - fetch_pc = RESET_PC.
  - fetch_valid = 1 on the first RUN cycle, provided RESET_PC word index < prog_len.
- RUN (load_ready = 0, imem_we = 0):
  - Next-PC priority, highest first:
    1. branch_taken: fetch_pc <= {branch_target[31:2], 2'b00}. If branch_target[1:0] != 0, set misalign_err. Branch wins over a simultaneous stall.
    2. stall: fetch_pc holds.
    3. otherwise: fetch_pc <= fetch_pc + 4, modulo 2**32.
  - fetch_valid = (fetch_pc[31:2] < prog_len), combinational, zero-extended compare.
  - Halt rule: when the registered next PC would have word index >= prog_len, state -> HALT at that edge. fetch_pc takes that out-of-range value.
  - Branch to an out-of-range target also halts.
  - stall=1 never causes a halt.
- HALT:
  - fetch_valid = 0, halted = 1, fetch_pc frozen.
  - stall and branch_taken are ignored.
  - restart=1: next state LOAD, write pointer = 0, prog_len = 0, fetch_pc = RESET_PC.
  - Sticky errors clear only on reset.
  - restart is ignored in LOAD and RUN.
- Latency:
  - PC update takes effect one cycle after the input edge.
  - Load writes are zero-latency relative to the handshake cycle.

Test Plan:
- Load 8 words (0x01095020, 0xAC0A0000, ..., last = 0x02939824 with load_last) at 1 word/cycle -> imem_we for 8 cycles, waddr 0..7, prog_len=8, RUN next cycle with fetch_pc=0, fetch_valid=1.
- Gapped load: load_valid toggled 1,0,0,1 with load_last on the 2nd word -> exactly 2 writes (waddr 0,1), no write on idle cycles, prog_len=2.
- RUN with prog_len=8, no stall -> fetch_pc 0,4,...,28. Then HALT with fetch_pc=32, fetch_valid=0, halted=1.
- At fetch_pc=8: stall for 2 cycles, then branch_taken with target 0x04 asserted together with stall -> PC 8,8,8, then 4. Branch wins, no halt.
- branch_target=0x06 -> fetch_pc=4, misalign_err=1. branch_target=0x100 with prog_len=8 -> HALT next cycle.
- Overflow: stream 1024 words, no load_last -> load_err=1, prog_len=1024, RUN. Then HALT + restart -> LOAD, prog_len=0. rst_n=0 mid-RUN -> LOAD, errors cleared.
